// File: rtl/adc_bask_pkg.sv
// Shared types, default ADC timing constants and width helper for the BASK ADC scheduler.
package adc_bask_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned SAMPLE_DIV_DEF = 64;
  localparam int unsigned HALF_DIV_DEF   = 1;
  localparam int unsigned SETUP_CYC_DEF  = 2;
  localparam int unsigned LEAD_BITS_DEF  = 2;
  localparam int unsigned WORD_BITS_DEF  = 10;
  localparam int unsigned OUT_BITS_DEF   = 8;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// Serial ADC read engine: generates sclk bit periods, captures sdata on each sclk rise
// and reports the final cycle of the last bit's high phase.
module adc_serial_shifter
  import adc_bask_pkg::*;
#(
  parameter int unsigned HALF_DIV  = HALF_DIV_DEF,
  parameter int unsigned LEAD_BITS = LEAD_BITS_DEF,
  parameter int unsigned WORD_BITS = WORD_BITS_DEF,
  parameter int unsigned OUT_BITS  = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                sdata_i,
  output logic                sclk_o,
  output logic                done_o,
  output logic [OUT_BITS-1:0] word_o
);

  localparam int unsigned NBITS = LEAD_BITS + WORD_BITS;
  localparam int unsigned HW    = clog2(HALF_DIV);
  localparam int unsigned BW    = clog2(NBITS);

  logic                 active_q;
  logic                 phase_q;   // 0: sclk low half, 1: sclk high half
  logic [HW-1:0]        half_q;
  logic [BW-1:0]        bit_q;
  logic                 sclk_q;
  logic [WORD_BITS-1:0] word_q;
  logic                 half_end;
  logic                 last_bit;

  assign half_end = (half_q == HW'(HALF_DIV - 1));
  assign last_bit = (bit_q == BW'(NBITS - 1));
  assign done_o   = active_q & phase_q & half_end & last_bit;
  assign sclk_o   = sclk_q;
  assign word_o   = word_q[WORD_BITS-1 -: OUT_BITS];

  // Bit-period sequencer; lead bits are shifted in too and fall off the top after
  // all NBITS captures, leaving exactly the last WORD_BITS samples in word_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      word_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
    end else if (active_q) begin
      if (half_end) begin
        half_q <= '0;
        if (!phase_q) begin
          phase_q <= 1'b1;
          sclk_q  <= 1'b1;
          word_q  <= {word_q[WORD_BITS-2:0], sdata_i};
        end else if (last_bit) begin
          active_q <= 1'b0;
          phase_q  <= 1'b0;
        end else begin
          phase_q <= 1'b0;
          sclk_q  <= 1'b0;
          bit_q   <= bit_q + 1'b1;
        end
      end else begin
        half_q <= half_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_bask_scheduler.sv
// Conversion scheduler: sample-rate divider, conversion FSM, output handshake register
// and sticky overrun/late flags around the serial shifter.
module adc_bask_scheduler
  import adc_bask_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = SAMPLE_DIV_DEF,
  parameter int unsigned HALF_DIV     = HALF_DIV_DEF,
  parameter int unsigned SETUP_CYC    = SETUP_CYC_DEF,
  parameter int unsigned LEAD_BITS    = LEAD_BITS_DEF,
  parameter int unsigned WORD_BITS    = WORD_BITS_DEF,
  parameter int unsigned OUT_BITS     = OUT_BITS_DEF,
  parameter bit          TIMING_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sdata,
  output logic                cs_n,
  output logic                sclk,
  output logic [OUT_BITS-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                overrun,
  output logic                late,
  input  logic                clr_flags
);

  localparam int unsigned NBITS = LEAD_BITS + WORD_BITS;
  localparam int unsigned DW    = clog2(SAMPLE_DIV);
  localparam int unsigned SW    = clog2(SETUP_CYC);

  if (SAMPLE_DIV < 2 || HALF_DIV == 0 || SETUP_CYC == 0 ||
      WORD_BITS < 2 || OUT_BITS > WORD_BITS) begin : g_bad_param
    $error("adc_bask_scheduler: illegal parameter set");
  end
  if (TIMING_CHECK && (SAMPLE_DIV < SETUP_CYC + 2 * HALF_DIV * NBITS + 3)) begin : g_bad_timing
    $error("adc_bask_scheduler: SAMPLE_DIV too short for one conversion");
  end

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q;
  logic [SW-1:0]       setup_q;
  logic                cs_n_q, cs_n_d;
  logic [OUT_BITS-1:0] sample_q;
  logic                valid_q, ovr_q, late_q;
  logic                tick, setup_end, start_shift, shift_done, xfer, load;
  logic [OUT_BITS-1:0] word_msbs;

  assign tick      = (div_q == DW'(SAMPLE_DIV - 1));
  assign setup_end = (setup_q == SW'(SETUP_CYC - 1));
  assign xfer      = valid_q & sample_ready;
  assign load      = (state_q == DONE) & (~valid_q | xfer);

  assign cs_n         = cs_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign late         = late_q;

  adc_serial_shifter #(
    .HALF_DIV (HALF_DIV),
    .LEAD_BITS(LEAD_BITS),
    .WORD_BITS(WORD_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst),
    .start_i(start_shift),
    .sdata_i(sdata),
    .sclk_o (sclk),
    .done_o (shift_done),
    .word_o (word_msbs)
  );

  // Free-running conversion-rate divider, independent of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  // Counts cycles spent in SETUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  setup_q <= '0;
    else if (state_q == SETUP) setup_q <= setup_q + 1'b1;
    else                       setup_q <= '0;
  end

  // FSM state register with registered chip select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick && enable) state_d = SETUP;
      SETUP:   if (setup_end)      state_d = SHIFT;
      SHIFT:   if (shift_done)     state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM outputs: chip select follows the upcoming state so it changes with the transition.
  always_comb begin
    cs_n_d      = ~((state_d == SETUP) || (state_d == SHIFT));
    busy        = (state_q != IDLE);
    start_shift = (state_q == SETUP) && setup_end;
  end

  // Output register and valid/ready handshake; a DONE load wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      sample_q <= word_msbs;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      valid_q  <= 1'b0;
    end
  end

  // Sticky flags; a clear request beats a set event in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q  <= 1'b0;
      late_q <= 1'b0;
    end else if (clr_flags) begin
      ovr_q  <= 1'b0;
      late_q <= 1'b0;
    end else begin
      if ((state_q == DONE) && !load)    ovr_q  <= 1'b1;
      if (tick && (state_q != IDLE))     late_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_bask_scheduler.sv
// Self-checking bench for adc_bask_scheduler: timeline model checked every cycle plus
// directed scenarios with literal expectations, and a second instance with a short period.
`timescale 1ns/1ps
module tb_adc_bask_scheduler;

  localparam int SD   = 64;
  localparam int H    = 1;
  localparam int S    = 2;
  localparam int LEAD = 2;
  localparam int WB   = 10;
  localparam int N    = LEAD + WB;
  localparam int L    = S + 2 * H * N + 1;  // tick-relative cycle of the DONE state

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, sdata, ready, clr;
  logic       cs_n, sclk, valid, busy, ovr, late;
  logic [7:0] sample;
  logic [9:0] adc_word;

  logic       rst_b, sdata_b, cs_n_b, sclk_b, valid_b, busy_b, ovr_b, late_b;
  logic [7:0] sample_b;
  logic [9:0] adc_word_b;

  int checks   = 0;
  int failures = 0;
  bit b_done   = 1'b0;
  int unsigned cyc = 0;

  adc_bask_scheduler #(
    .SAMPLE_DIV(64), .HALF_DIV(1), .SETUP_CYC(2), .LEAD_BITS(2), .WORD_BITS(10), .OUT_BITS(8)
  ) dut (
    .clk(clk), .rst(rst_n), .enable(enable), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
    .sample(sample), .sample_valid(valid), .sample_ready(ready), .busy(busy),
    .overrun(ovr), .late(late), .clr_flags(clr)
  );

  adc_bask_scheduler #(
    .SAMPLE_DIV(20), .TIMING_CHECK(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(1'b1), .sdata(sdata_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .sample(sample_b), .sample_valid(valid_b), .sample_ready(1'b1), .busy(busy_b),
    .overrun(ovr_b), .late(late_b), .clr_flags(1'b0)
  );

  always @(posedge clk) cyc++;

  // ADC models: lead bits are zero, then the word MSB-first, each bit put out on sclk fall.
  int unsigned aidx = 0;
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) begin
      aidx  = 0;
      sdata = 1'b0;
    end else begin
      if (aidx < LEAD || aidx >= N) sdata = 1'b0;
      else                          sdata = adc_word[WB - 1 - (aidx - LEAD)];
      aidx++;
    end
  end

  int unsigned bidx = 0;
  always @(negedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b) begin
      bidx    = 0;
      sdata_b = 1'b0;
    end else begin
      if (bidx < LEAD || bidx >= N) sdata_b = 1'b0;
      else                          sdata_b = adc_word_b[WB - 1 - (bidx - LEAD)];
      bidx++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a conversion started by the tick in cycle t0 occupies cycles t0+1..t0+L,
  // shifts during t0+S+1..t0+S+2HN and delivers at the end of cycle t0+L.
  int unsigned m_cyc = 0, m_div = 0, m_t0 = 0;
  bit          m_act = 1'b0;
  logic [9:0]  m_word = '0;
  logic [7:0]  e_sample = '0;
  bit e_valid = 0, e_ovr = 0, e_late = 0, e_cs_n = 1, e_sclk = 1, e_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    bit tick, xfer, set_ovr, done_now;
    int unsigned k;
    if (!rst_n) begin
      m_cyc = 0; m_div = 0; m_act = 0;
      e_sample = '0; e_valid = 0; e_ovr = 0; e_late = 0; e_cs_n = 1; e_sclk = 1; e_busy = 0;
    end else begin
      tick     = (m_div == SD - 1);
      m_div    = (m_div + 1) % SD;
      xfer     = e_valid && ready;
      done_now = m_act && (m_cyc == m_t0 + L);
      set_ovr  = 0;
      if (done_now) begin
        if (!e_valid || xfer) begin
          e_sample = m_word[9 -: 8];
          e_valid  = 1;
        end else begin
          set_ovr = 1;
        end
      end else if (xfer) begin
        e_valid = 0;
      end
      if (clr) begin
        e_ovr = 0; e_late = 0;
      end else begin
        if (set_ovr)        e_ovr  = 1;
        if (tick && m_act)  e_late = 1;
      end
      if (done_now) m_act = 0;
      else if (tick && enable && !m_act) begin
        m_act = 1; m_t0 = m_cyc; m_word = adc_word;
      end
      m_cyc++;
      e_busy = m_act;
      e_cs_n = !(m_act && m_cyc <= m_t0 + L - 1);
      e_sclk = 1;
      if (m_act && m_cyc >= m_t0 + S + 1 && m_cyc <= m_t0 + S + 2 * H * N) begin
        k = m_cyc - (m_t0 + S + 1);
        e_sclk = ((k / H) % 2) == 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cs_n",    32'(cs_n),   32'(e_cs_n));
    check("sclk",    32'(sclk),   32'(e_sclk));
    check("valid",   32'(valid),  32'(e_valid));
    check("sample",  32'(sample), 32'(e_sample));
    check("busy",    32'(busy),   32'(e_busy));
    check("overrun", 32'(ovr),    32'(e_ovr));
    check("late",    32'(late),   32'(e_late));
  end

  task automatic wait_cs(input logic lvl, input int budget);
    int n = 0;
    while (cs_n !== lvl && n < budget) begin @(negedge clk); n++; end
    if (cs_n !== lvl) begin
      checks++; failures++;
      $display("FAIL wait_cs: cs_n=%b required %b within %0d cycles", cs_n, lvl, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_valid: sample_valid=%b required 1 within %0d cycles", valid, budget);
    end
  endtask

  task automatic set_word(input logic [9:0] w);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL set_word: busy=%b required 0", busy);
    end
    adc_word = w;
  endtask

  // Main directed sequence.
  initial begin
    int unsigned t_fall;
    int low, falls;
    logic [9:0] words [4];
    logic [7:0] exps  [4];
    words = '{10'h000, 10'h003, 10'h3FC, 10'h0E9};
    exps  = '{8'h00,   8'h00,   8'hFF,   8'h3A};

    rst_n = 1'b0; enable = 1'b0; ready = 1'b1; clr = 1'b0;
    adc_word = 10'b1100100011;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; enable = 1'b1;

    // Basic conversion: C8, latency and chip-select width.
    wait_cs(1'b0, 200);
    t_fall = cyc;
    low = 0;
    while (cs_n == 1'b0 && low < 100) begin low++; @(negedge clk); end
    check("cs_low_cycles", 32'(low), 32'd26);
    wait_valid(20);
    check("latency_from_cs_fall", 32'(cyc - t_fall), 32'd27);
    check("sample_C8", 32'(sample), 32'hC8);
    @(negedge clk);
    check("valid_single_pulse", 32'(valid), 32'd0);

    // Reset in the middle of SHIFT.
    set_word(10'h3FF);
    wait_cs(1'b0, 200);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_valid(200);
    check("after_rst_sample_FF", 32'(sample), 32'hFF);
    @(negedge clk);

    // Extreme words and LSB independence.
    for (int i = 0; i < 4; i++) begin
      set_word(words[i]);
      wait_cs(1'b0, 200);
      wait_valid(60);
      check("table_sample", 32'(sample), 32'(exps[i]));
      @(negedge clk);
    end

    // Overrun: ready held low across two conversions.
    ready = 1'b0;
    set_word(10'b1100100011);
    wait_cs(1'b0, 200);
    wait_cs(1'b1, 60);
    @(negedge clk);
    check("ovr_first_sample", 32'(sample), 32'hC8);
    set_word(10'h0E9);
    wait_cs(1'b0, 200);
    wait_cs(1'b1, 60);
    @(negedge clk);
    check("ovr_sample_kept", 32'(sample), 32'hC8);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(ovr), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_transfer_clears_valid", 32'(valid), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_flags_overrun", 32'(ovr), 32'd0);

    // Delivery in the same cycle as a transfer of the previous sample.
    set_word(10'h155);
    wait_cs(1'b0, 200);
    wait_cs(1'b1, 60);
    @(negedge clk);
    check("held_sample_55", 32'(sample), 32'h55);
    set_word(10'h2A8);
    wait_cs(1'b0, 200);
    wait_cs(1'b1, 60);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("same_cycle_valid", 32'(valid), 32'd1);
    check("same_cycle_sample", 32'(sample), 32'hAA);
    check("same_cycle_no_ovr", 32'(ovr), 32'd0);
    ready = 1'b1;
    @(negedge clk);

    // Enable dropped mid-SHIFT: this conversion still delivers, nothing afterwards.
    set_word(10'h0F0);
    wait_cs(1'b0, 200);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    wait_valid(60);
    check("enable_drop_sample", 32'(sample), 32'h3C);
    falls = 0;
    repeat (150) begin
      @(negedge clk);
      if (cs_n == 1'b0) falls++;
    end
    check("no_cs_after_disable", 32'(falls), 32'd0);
    check("idle_after_disable", 32'(busy), 32'd0);

    for (int n = 0; n < 1000 && !b_done; n++) @(negedge clk);
    if (!b_done) begin
      checks++; failures++;
      $display("FAIL short_period_bench: not finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Short-period instance: the tick at cycle 39 lands mid-SHIFT and must only flag late.
  initial begin
    int falls, vcount;
    logic prev;
    adc_word_b = 10'h2A5;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    falls = 0; vcount = 0; prev = 1'b1;
    repeat (90) begin
      @(negedge clk);
      if (prev && !cs_n_b) falls++;
      prev = cs_n_b;
      if (valid_b) vcount++;
    end
    check("short_starts", 32'(falls), 32'd2);
    check("short_late", 32'(late_b), 32'd1);
    check("short_valid_pulses", 32'(vcount), 32'd2);
    check("short_sample_A9", 32'(sample_b), 32'hA9);
    check("short_no_overrun", 32'(ovr_b), 32'd0);
    b_done = 1'b1;
  end

endmodule
